// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : ASCII constants, reporter FSM states, hex-to-ASCII helper |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package uart_pkg;

    localparam logic [7:0] C_ASCII_CR    = 8'h0D;
    localparam logic [7:0] C_ASCII_LF    = 8'h0A;
    localparam logic [7:0] C_ASCII_COLON = 8'h3A;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PREFIX = 3'd1,
        ST_COLON  = 3'd2,
        ST_DIGIT  = 3'd3,
        ST_CR     = 3'd4,
        ST_LF     = 3'd5
    } rpt_state_t;

    // Uppercase hex: 0-9 -> '0'..'9', 10-15 -> 'A'..'F' ('A' - 10 = 8'h37)
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_hex_reporter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_hex_reporter : frames a captured value as "P:HHHH\r\n" bytes    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module uart_hex_reporter
    import uart_pkg::*;
#(
    parameter int unsigned NIBBLES   = 4,
    parameter logic [7:0]  PREFIX    = 8'h52,
    parameter bit          SEND_CRLF = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*NIBBLES-1:0]   report_value,
    input  logic                   report_start,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready
);

    localparam int unsigned VW = 4 * NIBBLES;
    localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    rpt_state_t       r_state;
    logic [VW-1:0]    r_shift;
    logic [CW-1:0]    r_dcnt;
    logic             r_pend_valid;
    logic [VW-1:0]    r_pend_value;
    logic [7:0]       r_tx_data;
    logic             r_tx_valid;
    logic             r_busy;
    logic             r_done;
    logic             r_overrun;

    logic             w_xfer;
    logic             w_last_digit;
    logic             w_frame_end;
    logic [VW-1:0]    w_shifted;

    assign w_xfer       = r_tx_valid & tx_ready;
    assign w_last_digit = (r_dcnt == '0);
    assign w_shifted    = r_shift << 4;
    assign w_frame_end  = w_xfer &&
                          ((r_state == ST_LF) ||
                           ((r_state == ST_DIGIT) && w_last_digit && !SEND_CRLF));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_dcnt       <= '0;
            r_pend_valid <= 1'b0;
            r_pend_value <= '0;
            r_tx_data    <= 8'h00;
            r_tx_valid   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_done    <= w_frame_end;
            r_overrun <= report_start && r_busy && r_pend_valid;

            // A request landing on the frame-end transfer bypasses the buffer below
            if (report_start && r_busy && !r_pend_valid && !w_frame_end) begin
                r_pend_valid <= 1'b1;
                r_pend_value <= report_value;
            end

            case (r_state)
                ST_IDLE: begin
                    if (report_start) begin
                        r_state    <= ST_PREFIX;
                        r_shift    <= report_value;
                        r_tx_data  <= PREFIX;
                        r_tx_valid <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                ST_PREFIX: begin
                    if (w_xfer) begin
                        r_state   <= ST_COLON;
                        r_tx_data <= C_ASCII_COLON;
                    end
                end
                ST_COLON: begin
                    if (w_xfer) begin
                        r_state   <= ST_DIGIT;
                        r_dcnt    <= CW'(NIBBLES - 1);
                        r_tx_data <= hex_ascii(r_shift[VW-1 -: 4]);
                    end
                end
                ST_DIGIT: begin
                    if (w_xfer) begin
                        if (!w_last_digit) begin
                            r_shift   <= w_shifted;
                            r_dcnt    <= r_dcnt - 1'b1;
                            r_tx_data <= hex_ascii(w_shifted[VW-1 -: 4]);
                        end else if (SEND_CRLF) begin
                            r_state   <= ST_CR;
                            r_tx_data <= C_ASCII_CR;
                        end
                    end
                end
                ST_CR: begin
                    if (w_xfer) begin
                        r_state   <= ST_LF;
                        r_tx_data <= C_ASCII_LF;
                    end
                end
                ST_LF: begin
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_tx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase

            // Frame end overrides the per-state update: chain the next frame or go idle
            if (w_frame_end) begin
                if (r_pend_valid || report_start) begin
                    r_state      <= ST_PREFIX;
                    r_shift      <= r_pend_valid ? r_pend_value : report_value;
                    r_tx_data    <= PREFIX;
                    r_pend_valid <= 1'b0;
                end else begin
                    r_state    <= ST_IDLE;
                    r_tx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                end
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign overrun  = r_overrun;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;

endmodule
`default_nettype wire

// File: tb/tb_uart_hex_reporter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_hex_reporter : randomized self-checking bench for the framer |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_uart_hex_reporter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] report_value;
    logic        report_start;
    logic        busy, done, overrun, tx_valid, tx_ready;
    logic [7:0]  tx_data;

    logic [7:0]  value2;
    logic        start2, ready2;
    logic        busy2, done2, overrun2, valid2;
    logic [7:0]  data2;

    uart_hex_reporter dut (
        .clk(clk), .rst(rst), .report_value(report_value), .report_start(report_start),
        .busy(busy), .done(done), .overrun(overrun),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    uart_hex_reporter #(.NIBBLES(2), .PREFIX(8'h52), .SEND_CRLF(1'b0)) dut2 (
        .clk(clk), .rst(rst), .report_value(value2), .report_start(start2),
        .busy(busy2), .done(done2), .overrun(overrun2),
        .tx_data(data2), .tx_valid(valid2), .tx_ready(ready2)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] got[$];
    int         got_cyc[$];
    int         done_cyc[$];
    int         ovr_cyc[$];
    logic [7:0] got2[$];
    int         got2_cyc[$];
    int         done2_cyc[$];
    logic [7:0] exp_q[$];
    int         stall_err = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    // Observe the line mid-cycle: transfers, pulses, and hold-while-stalled behaviour
    always @(negedge clk) begin
        if (prev_stall && (!tx_valid || tx_data !== prev_data)) stall_err++;
        prev_stall = tx_valid && !tx_ready && !rst;
        prev_data  = tx_data;
        if (!rst && tx_valid && tx_ready) begin
            got.push_back(tx_data);
            got_cyc.push_back(cyc);
        end
        if (!rst && valid2 && ready2) begin
            got2.push_back(data2);
            got2_cyc.push_back(cyc);
        end
        if (done)    done_cyc.push_back(cyc);
        if (overrun) ovr_cyc.push_back(cyc);
        if (done2)   done2_cyc.push_back(cyc);
    end

    function automatic void push_frame(input logic [31:0] v, input int nib, input bit crlf);
        exp_q.push_back(8'h52);
        exp_q.push_back(8'h3A);
        for (int i = nib - 1; i >= 0; i--) begin
            int d;
            d = int'((v >> (4 * i)) & 32'hF);
            exp_q.push_back(d < 10 ? 8'(48 + d) : 8'(55 + d));
        end
        if (crlf) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endfunction

    function automatic string q2s(input logic [7:0] q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
        return s;
    endfunction

    function automatic bit q_differs(input logic [7:0] a[$], input logic [7:0] b[$]);
        if (a.size() != b.size()) return 1'b1;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        got.delete(); got_cyc.delete(); done_cyc.delete(); ovr_cyc.delete();
        got2.delete(); got2_cyc.delete(); done2_cyc.delete();
        exp_q.delete();
        stall_err = 0;
    endtask

    task automatic wait_done(input int n, input int budget, input bit rnd);
        int k = 0;
        while (done_cyc.size() < n && k < budget) begin
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            k++;
        end
        tx_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; report_start = 1'b0; report_value = '0; tx_ready = 1'b1;
        start2 = 1'b0; value2 = '0; ready2 = 1'b1;
        repeat (3) tick();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b required 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %02h required 00", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (done !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_pulses: got done=%b overrun=%b required 0 0", done, overrun); end
        checks++; if (valid2 !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL reset_variant: got valid=%b busy=%b required 0 0", valid2, busy2); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int n;
        bit busy_ok = 1'b1;
        bit cyc_ok = 1'b1;
        clear_mon();
        tx_ready = 1'b1;
        report_value = 16'h1A3F; report_start = 1'b1; n = cyc;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle: got %b required 0", busy); end
        tick();
        report_start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (busy !== (k <= 8)) busy_ok = 1'b0;
            tick();
        end
        push_frame(32'h1A3F, 4, 1'b1);
        checks++; if (q_differs(got, exp_q)) begin errors++; $display("FAIL basic_bytes: got %s required %s", q2s(got), q2s(exp_q)); end
        foreach (got_cyc[i]) if (got_cyc[i] != n + 1 + i) cyc_ok = 1'b0;
        checks++; if (!cyc_ok) begin errors++; $display("FAIL basic_timing: bytes not in cycles N+1..N+8 (N=%0d first=%0d)", n, got_cyc.size() ? got_cyc[0] : -1); end
        checks++; if (done_cyc.size() != 1 || done_cyc[0] != n + 9) begin errors++; $display("FAIL basic_done: got %0d pulses first at %0d required 1 at %0d", done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1, n + 9); end
        checks++; if (!busy_ok) begin errors++; $display("FAIL basic_busy: got busy window wrong required N+1..N+8"); end
    endtask

    task automatic test_backpressure();
        clear_mon();
        report_value = 16'hBEEF; report_start = 1'b1;
        tick();
        report_start = 1'b0;
        wait_done(1, 300, 1'b1);
        push_frame(32'hBEEF, 4, 1'b1);
        checks++; if (q_differs(got, exp_q)) begin errors++; $display("FAIL bp_bytes: got %s required %s", q2s(got), q2s(exp_q)); end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_stable: got %0d hold violations required 0", stall_err); end
        checks++; if (done_cyc.size() != 1) begin errors++; $display("FAIL bp_done: got %0d pulses required 1", done_cyc.size()); end
    endtask

    task automatic test_queued();
        int n;
        bit busy_ok = 1'b1;
        clear_mon();
        report_value = 16'h0001; report_start = 1'b1; n = cyc;
        tick();
        for (int k = 1; k <= 18; k++) begin
            report_start = (k == 3);
            report_value = 16'h0000;
            if (busy !== (k <= 16)) busy_ok = 1'b0;
            tick();
        end
        report_start = 1'b0;
        push_frame(32'h0001, 4, 1'b1);
        push_frame(32'h0000, 4, 1'b1);
        checks++; if (q_differs(got, exp_q)) begin errors++; $display("FAIL queued_bytes: got %s required %s", q2s(got), q2s(exp_q)); end
        checks++; if (done_cyc.size() != 2 || done_cyc[0] != n + 9 || done_cyc[1] != n + 17) begin errors++; $display("FAIL queued_done: got %0d pulses required 2 at %0d and %0d", done_cyc.size(), n + 9, n + 17); end
        checks++; if (!busy_ok) begin errors++; $display("FAIL queued_busy: got busy drop required continuous N+1..N+16"); end
        checks++; if (got_cyc.size() != 16 || got_cyc[15] != n + 16) begin errors++; $display("FAIL queued_gap: got last byte at %0d required %0d", got_cyc.size() ? got_cyc[got_cyc.size() - 1] : -1, n + 16); end
    endtask

    task automatic test_overrun();
        int n;
        logic [15:0] a, b, c;
        clear_mon();
        a = 16'($urandom); b = 16'($urandom); c = b ^ 16'hFFFF;
        report_value = a; report_start = 1'b1; n = cyc;
        tick();
        for (int k = 1; k <= 24; k++) begin
            report_start = (k == 2) || (k == 4);
            report_value = (k == 2) ? b : c;
            tick();
        end
        report_start = 1'b0;
        push_frame(32'(a), 4, 1'b1);
        push_frame(32'(b), 4, 1'b1);
        checks++; if (q_differs(got, exp_q)) begin errors++; $display("FAIL overrun_bytes: got %s required %s", q2s(got), q2s(exp_q)); end
        checks++; if (ovr_cyc.size() != 1 || ovr_cyc[0] != n + 5) begin errors++; $display("FAIL overrun_pulse: got %0d pulses first at %0d required 1 at %0d", ovr_cyc.size(), ovr_cyc.size() ? ovr_cyc[0] : -1, n + 5); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b;
        clear_mon();
        a = 16'($urandom); b = 16'($urandom);
        report_value = a; report_start = 1'b1;
        tick();
        for (int k = 1; k <= 22; k++) begin
            report_start = (k == 8);
            report_value = b;
            tick();
        end
        report_start = 1'b0;
        push_frame(32'(a), 4, 1'b1);
        push_frame(32'(b), 4, 1'b1);
        checks++; if (q_differs(got, exp_q)) begin errors++; $display("FAIL b2b_bytes: got %s required %s", q2s(got), q2s(exp_q)); end
        checks++; if (ovr_cyc.size() != 0 || done_cyc.size() != 2) begin errors++; $display("FAIL b2b_pulses: got overrun=%0d done=%0d required 0 and 2", ovr_cyc.size(), done_cyc.size()); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] z;
        clear_mon();
        report_value = 16'h1234; report_start = 1'b1;
        tick();
        report_start = 1'b0;
        tick();
        report_value = 16'h5678; report_start = 1'b1;
        tick();
        report_start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: got valid=%b busy=%b required 0 0", tx_valid, busy); end
        got.delete(); done_cyc.delete();
        repeat (20) tick();
        checks++; if (got.size() != 0 || done_cyc.size() != 0) begin errors++; $display("FAIL rstmid_quiet: got %0d bytes %0d done required 0 0", got.size(), done_cyc.size()); end
        z = 16'($urandom);
        report_value = z; report_start = 1'b1;
        tick();
        report_start = 1'b0;
        wait_done(1, 100, 1'b0);
        repeat (10) tick();
        push_frame(32'(z), 4, 1'b1);
        checks++; if (q_differs(got, exp_q)) begin errors++; $display("FAIL rstmid_clean: got %s required %s", q2s(got), q2s(exp_q)); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            logic [15:0] v;
            clear_mon();
            v = 16'($urandom);
            report_value = v; report_start = 1'b1;
            tick();
            report_start = 1'b0;
            wait_done(1, 300, 1'b1);
            push_frame(32'(v), 4, 1'b1);
            checks++; if (q_differs(got, exp_q) || stall_err != 0) begin errors++; $display("FAIL random_frame%0d: got %s (holds bad %0d) required %s", it, q2s(got), stall_err, q2s(exp_q)); end
        end
    endtask

    task automatic test_variant();
        for (int it = 0; it < 2; it++) begin
            logic [7:0] v;
            int k;
            clear_mon();
            v = (it == 0) ? 8'hC5 : 8'($urandom);
            value2 = v; start2 = 1'b1;
            tick();
            start2 = 1'b0;
            k = 0;
            while (done2_cyc.size() < 1 && k < 60) begin
                ready2 = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                tick();
                k++;
            end
            ready2 = 1'b1;
            repeat (3) tick();
            push_frame(32'(v), 2, 1'b0);
            checks++; if (q_differs(got2, exp_q)) begin errors++; $display("FAIL variant_bytes%0d: got %s required %s", it, q2s(got2), q2s(exp_q)); end
            checks++; if (done2_cyc.size() != 1 || got2_cyc.size() != 4 || done2_cyc[0] != got2_cyc[3] + 1) begin errors++; $display("FAIL variant_done%0d: got %0d pulses at %0d required 1 after last byte", it, done2_cyc.size(), done2_cyc.size() ? done2_cyc[0] : -1); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_queued();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_variant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
